// File: rtl/dctq_zz_rle.sv
// Ping-pong block buffer behind DCTQ: captures raster-order coefficients and
// re-emits each completed block as zigzag (run, level) symbols ending in EOB.
`timescale 1ns/1ps
module dctq_zz_rle #(
    parameter int CW   = 9,
    parameter int RUNW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CW-1:0]   dctq,
    input  logic            dctq_valid,
    input  logic [5:0]      addr,
    output logic            hold,
    output logic [RUNW-1:0] rle_run,
    output logic [CW-1:0]   rle_level,
    output logic            rle_eob,
    output logic            rle_valid,
    input  logic            rle_ready,
    output logic            blk_done,
    output logic            ovf
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DC = 2'd1, S_SCAN = 2'd2, S_EOB = 2'd3} state_t;
    typedef enum logic [1:0] {T_DC = 2'd0, T_AC = 2'd1, T_EOB = 2'd2} tok_t;

    function automatic logic [5:0] zz_raster(input logic [5:0] k);
        logic [5:0] z;
        case (k)
            6'd0:  z = 6'd0;  6'd1:  z = 6'd1;  6'd2:  z = 6'd8;  6'd3:  z = 6'd16;
            6'd4:  z = 6'd9;  6'd5:  z = 6'd2;  6'd6:  z = 6'd3;  6'd7:  z = 6'd10;
            6'd8:  z = 6'd17; 6'd9:  z = 6'd24; 6'd10: z = 6'd32; 6'd11: z = 6'd25;
            6'd12: z = 6'd18; 6'd13: z = 6'd11; 6'd14: z = 6'd4;  6'd15: z = 6'd5;
            6'd16: z = 6'd12; 6'd17: z = 6'd19; 6'd18: z = 6'd26; 6'd19: z = 6'd33;
            6'd20: z = 6'd40; 6'd21: z = 6'd48; 6'd22: z = 6'd41; 6'd23: z = 6'd34;
            6'd24: z = 6'd27; 6'd25: z = 6'd20; 6'd26: z = 6'd13; 6'd27: z = 6'd6;
            6'd28: z = 6'd7;  6'd29: z = 6'd14; 6'd30: z = 6'd21; 6'd31: z = 6'd28;
            6'd32: z = 6'd35; 6'd33: z = 6'd42; 6'd34: z = 6'd49; 6'd35: z = 6'd56;
            6'd36: z = 6'd57; 6'd37: z = 6'd50; 6'd38: z = 6'd43; 6'd39: z = 6'd36;
            6'd40: z = 6'd29; 6'd41: z = 6'd22; 6'd42: z = 6'd15; 6'd43: z = 6'd23;
            6'd44: z = 6'd30; 6'd45: z = 6'd37; 6'd46: z = 6'd44; 6'd47: z = 6'd51;
            6'd48: z = 6'd58; 6'd49: z = 6'd59; 6'd50: z = 6'd52; 6'd51: z = 6'd45;
            6'd52: z = 6'd38; 6'd53: z = 6'd31; 6'd54: z = 6'd39; 6'd55: z = 6'd46;
            6'd56: z = 6'd53; 6'd57: z = 6'd60; 6'd58: z = 6'd61; 6'd59: z = 6'd54;
            6'd60: z = 6'd47; 6'd61: z = 6'd55; 6'd62: z = 6'd62; 6'd63: z = 6'd63;
            default: z = 6'd0;
        endcase
        return z;
    endfunction

    logic [CW-1:0]   r_mem [0:127];
    logic [1:0]      r_full;
    logic            r_wbank, r_rbank;
    state_t          r_state;
    logic [5:0]      r_idx;
    logic            r_eob_issued;
    logic            r_b_vld;
    tok_t            r_b_tok;
    logic [CW-1:0]   r_b_data;
    logic [RUNW-1:0] r_run_cnt;
    logic            r_valid, r_eob, r_done, r_ovf;
    logic [RUNW-1:0] r_run;
    logic [CW-1:0]   r_level;

    state_t          w_state_nxt;
    logic            w_wr, w_release, w_stall, w_issue, w_load, w_neob;
    tok_t            w_tok;
    logic [5:0]      w_ridx;
    logic [RUNW-1:0] w_nrun;
    logic [CW-1:0]   w_nlevel;
    logic [1:0]      w_full_nxt;

    assign hold      = r_full[r_wbank];
    assign w_wr      = dctq_valid & ~hold;
    assign w_stall   = r_valid & ~rle_ready;
    assign w_release = r_valid & rle_ready & r_eob;

    assign rle_run   = r_run;
    assign rle_level = r_level;
    assign rle_eob   = r_eob;
    assign rle_valid = r_valid;
    assign blk_done  = r_done;
    assign ovf       = r_ovf;

    // Full flags: a completing write and a released read bank can land on the same edge
    always_comb begin
        w_full_nxt = r_full;
        if (w_release) w_full_nxt[r_rbank] = 1'b0;
        else           w_full_nxt = w_full_nxt;
        if (w_wr && addr == 6'd63) w_full_nxt[r_wbank] = 1'b1;
        else                       w_full_nxt = w_full_nxt;
    end

    // Buffer write port and 1-cycle synchronous read port (frozen while stalled)
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[{r_wbank, addr}] <= dctq;
        if (!w_stall) r_b_data <= r_mem[{r_rbank, zz_raster(w_ridx)}];
    end

    // Bank bookkeeping and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full  <= 2'b00;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr && addr == 6'd63) r_wbank <= ~r_wbank;
            if (w_release) r_rbank <= ~r_rbank;
            if (dctq_valid && hold) r_ovf <= 1'b1;
            r_done <= w_release;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Read FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_full[r_rbank]) w_state_nxt = S_DC; else w_state_nxt = S_IDLE;
            S_DC:   if (!w_stall) w_state_nxt = S_SCAN; else w_state_nxt = S_DC;
            S_SCAN: if (!w_stall && r_idx == 6'd63) w_state_nxt = S_EOB; else w_state_nxt = S_SCAN;
            S_EOB:  if (w_release) w_state_nxt = S_IDLE; else w_state_nxt = S_EOB;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read FSM outputs: which token enters the data stage this cycle
    always_comb begin
        w_issue = 1'b0;
        w_tok   = T_AC;
        w_ridx  = r_idx;
        case (r_state)
            S_IDLE: w_issue = 1'b0;
            S_DC:   begin w_issue = 1'b1; w_tok = T_DC; w_ridx = 6'd0; end
            S_SCAN: begin w_issue = 1'b1; w_tok = T_AC; end
            S_EOB:  begin w_issue = ~r_eob_issued; w_tok = T_EOB; end
            default: w_issue = 1'b0;
        endcase
    end

    // Symbol formation from the data stage; zero AC coefficients only grow the run
    always_comb begin
        w_load   = 1'b0;
        w_nrun   = '0;
        w_nlevel = '0;
        w_neob   = 1'b0;
        if (r_b_vld) begin
            case (r_b_tok)
                T_DC:  begin w_load = 1'b1; w_nlevel = r_b_data; end
                T_AC:  if (r_b_data != '0) begin
                           w_load = 1'b1; w_nrun = r_run_cnt; w_nlevel = r_b_data;
                       end else begin
                           w_load = 1'b0;
                       end
                T_EOB: begin w_load = 1'b1; w_neob = 1'b1; end
                default: w_load = 1'b0;
            endcase
        end else begin
            w_load = 1'b0;
        end
    end

    // Scan pipeline and output register; everything holds while the output is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= 6'd0;
            r_eob_issued <= 1'b0;
            r_b_vld      <= 1'b0;
            r_b_tok      <= T_DC;
            r_run_cnt    <= '0;
            r_valid      <= 1'b0;
            r_run        <= '0;
            r_level      <= '0;
            r_eob        <= 1'b0;
        end else begin
            if (r_state != S_EOB) r_eob_issued <= 1'b0;
            else if (!w_stall)    r_eob_issued <= 1'b1;
            if (!w_stall) begin
                if (r_state == S_DC)        r_idx <= 6'd1;
                else if (r_state == S_SCAN) r_idx <= r_idx + 6'd1;
                r_b_vld <= w_issue;
                r_b_tok <= w_tok;
                if (r_b_vld) begin
                    if (r_b_tok == T_AC && r_b_data == '0) r_run_cnt <= r_run_cnt + RUNW'(1);
                    else                                    r_run_cnt <= '0;
                end
                r_valid <= w_load;
                if (w_load) begin
                    r_run   <= w_nrun;
                    r_level <= w_nlevel;
                    r_eob   <= w_neob;
                end
            end
        end
    end
endmodule

// File: doc/dctq_zz_rle.md
Name: dctq_zz_rle

Overview:
- Downstream consumer of the DCTQ stage. Captures the quantized coefficients that DCTQ emits in raster order (dctq, dctq_valid, addr) into a ping-pong block buffer.
- Re-reads each completed block in JPEG zigzag order and emits (run, level) symbols plus an end-of-block symbol to the entropy coder.
- Drives DCTQ's hold input to apply backpressure when both banks are occupied.

Parameters:
CW, 9, coefficient width (two's complement); matches the DCTQ dctq output
RUNW, 6, zero-run field width; covers runs 0..62

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
dctq  in  CW  quantized coefficient from DCTQ
dctq_valid  in  1  dctq/addr valid this cycle
addr  in  6  raster index 0..63 of dctq within the block
hold  out  1  to DCTQ hold; high = DCTQ must freeze
rle_run  out  RUNW  count of zero coefficients preceding rle_level
rle_level  out  CW  nonzero coefficient (DC symbol: any value)
rle_eob  out  1  symbol is end-of-block (run=0, level=0)
rle_valid  out  1  symbol valid
rle_ready  in  1  downstream accepts symbol when rle_valid and rle_ready are both high
blk_done  out  1  one-cycle pulse when a bank is released after its EOB is accepted
ovf  out  1  sticky flag: dctq_valid was seen while hold was high

Behaviour:
- Reset values: hold=0, rle_valid=0, rle_eob=0, rle_run=0, rle_level=0, blk_done=0, ovf=0. Both banks empty, wbank=0, rbank=0, FSM=IDLE.
- Reset asserted mid-block discards all buffered and partial data. No symbol is emitted after reset.
- Buffer: 2 banks x 64 x CW. Read is synchronous with 1-cycle latency.
- Write side:
  - When dctq_valid=1 and hold=0, write dctq to bank[wbank][addr].
  - A write with addr=63 sets full[wbank] and toggles wbank on the same edge.
  - Addresses arriving out of order are still written by address. Block completion is defined only by addr=63.
- hold is combinational: hold = full[wbank].
- dctq_valid while hold=1: write is dropped and ovf is set.
- Read FSM:
  - IDLE -> DC when full[rbank]=1. Issues a read of zigzag index 0.
  - DC: emits a symbol with run=0, level=coef. The DC symbol is always emitted, even when zero. Next state is SCAN, idx=1, run=0.
  - SCAN: reads zz[idx] each cycle. A zero coefficient increments run. A nonzero coefficient emits (run, coef) and clears run. After idx=63 is evaluated, go to EOB.
  - EOB: emits run=0, level=0, rle_eob=1. EOB is always emitted, even when zz[63] is nonzero.
  - On EOB acceptance: clear full[rbank], toggle rbank, pulse blk_done, go to IDLE. If the other bank is already full, IDLE goes straight to DC next cycle.
- Zigzag order is the standard JPEG 8x8 table (0,1,8,16,9,2,3,10,...,55,62,63) held in an internal 64-entry ROM.
- Output register:
  - rle_run, rle_level and rle_eob hold stable while rle_valid=1 and rle_ready=0.
  - The scan pipeline (address and read data) stalls whenever the output register is occupied and not being accepted.
  - No symbol is lost or duplicated under any stall pattern.
- Throughput: one zigzag index per cycle when rle_ready stays high.
- Latency: with the read side IDLE and rle_ready=1, the DC symbol's rle_valid rises on the 3rd rising edge after the edge that writes addr=63.
- Simultaneous events:
  - A block completing on the write side in the same cycle as the read side releases the other bank: both full-flag updates take effect.
  - hold is evaluated from post-edge state.
  - Writing a bank never corrupts the bank being read.

Test Plan:
- All-zero block, rle_ready=1 -> exactly 2 symbols: DC (run 0, level 0) then EOB; blk_done pulses once after EOB is accepted.
- Raster[0]=-16 (9'h1F0), raster[1]=5, raster[16]=-1 (9'h1FF), rest 0 -> symbols (0,9'h1F0), (0,5), (1,9'h1FF), EOB.
- Only raster[63]=7 -> (0,0), (62,7), EOB; rle_run=62 with no wrap.
- rle_ready toggled at random (~50%) over 20 random blocks -> symbol stream identical to a reference model; outputs stable while stalled.
- rle_ready=0, feed 3 blocks -> hold rises after the 2nd block's addr=63 write; a dctq_valid during hold sets ovf; releasing rle_ready drains both banks in order and drops hold.
- Reset asserted mid-scan of block 1 -> outputs return to reset values immediately; a fresh block after reset yields a correct stream starting with its DC symbol.
